// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   NUM_BANKS   : number of byte-wide SRAM banks
//   BANK_DW     : data width of one bank
//   mem_owner_e : which port owns the read response of the previous cycle
//   lsu_req_t   : one LSU request (we, be, addr, wdata)
package mem_pkg;

    localparam int unsigned NUM_BANKS = 4;
    localparam int unsigned BANK_DW   = 8;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_LSU
    } mem_owner_e;

    typedef struct packed {
        logic                           we;
        logic [NUM_BANKS-1:0]           be;
        logic [31:0]                    addr;
        logic [NUM_BANKS*BANK_DW-1:0]   wdata;
    } lsu_req_t;

endpackage

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares one 4-bank byte-wide SRAM (active-low CEN/GWEN/WEN) between the
// instruction-fetch port and the LSU port. One access per cycle, grants are
// combinational, read data returns the cycle after the grant.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr           fetch read request (level) and byte address
//   if_gnt                   fetch accepted this cycle
//   if_rvalid/if_rdata       fetch read response
//   lsu_req/we/be/addr/wdata LSU request (level), store when we=1
//   lsu_gnt                  LSU accepted this cycle
//   lsu_rvalid/lsu_rdata     load response
//   CEN/GWEN/WEN/A/D         per-bank SRAM controls (active low enables)
//   Q                        per-bank SRAM read data, valid after the access
//
// Build option: ARB_ROUND_ROBIN_EN selects alternating priority on
// contention instead of LSU priority with a fetch starvation guard.
module sram_port_arbiter
    import mem_pkg::*;
#(
    parameter int BANK_AW    = 9,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic               if_gnt,
    output logic               if_rvalid,
    output logic [31:0]        if_rdata,
    input  logic               lsu_req,
    input  logic               lsu_we,
    input  logic [3:0]         lsu_be,
    input  logic [31:0]        lsu_addr,
    input  logic [31:0]        lsu_wdata,
    output logic               lsu_gnt,
    output logic               lsu_rvalid,
    output logic [31:0]        lsu_rdata,
    output logic               CEN  [0:3],
    output logic               GWEN [0:3],
    output logic [7:0]         WEN  [0:3],
    output logic [BANK_AW-1:0] A    [0:3],
    output logic [7:0]         D    [0:3],
    input  logic [7:0]         Q    [0:3]
);

    lsu_req_t           lsu_acc;
    mem_owner_e         owner;
    logic               any_gnt;
    logic               store_gnt;
    logic [31:0]        sel_addr;
    logic [BANK_AW-1:0] word_idx;
    logic               unused_addr_bits;

    assign lsu_acc = '{we: lsu_we, be: lsu_be, addr: lsu_addr, wdata: lsu_wdata};

`ifdef ARB_ROUND_ROBIN_EN
    mem_owner_e last_win;
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;
`endif

    // Grants are forced low during reset so nothing issued in a reset
    // cycle can produce a response.
    always_comb begin
        if_gnt  = 1'b0;
        lsu_gnt = 1'b0;
        if (!rst) begin
            if (if_req && lsu_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                if_gnt = (last_win == OWN_LSU);
`else
                if_gnt = (starve_cnt == STARVE_LIM);
`endif
                lsu_gnt = !if_gnt;
            end else begin
                if_gnt  = if_req;
                lsu_gnt = lsu_req;
            end
        end
    end

    assign any_gnt   = if_gnt || lsu_gnt;
    assign store_gnt = lsu_gnt && lsu_acc.we;
    assign sel_addr  = if_gnt ? if_addr : lsu_acc.addr;
    assign word_idx  = sel_addr[BANK_AW+1:2];

    assign unused_addr_bits = ^{if_addr[31:BANK_AW+2], if_addr[1:0],
                                lsu_acc.addr[31:BANK_AW+2], lsu_acc.addr[1:0]};

    always_comb begin
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            CEN[i]  = !any_gnt;
            A[i]    = any_gnt ? word_idx : '0;
            GWEN[i] = 1'b1;
            WEN[i]  = '1;
            D[i]    = '0;
            if (store_gnt) begin
                GWEN[i] = ~lsu_acc.be[i];
                WEN[i]  = {BANK_DW{~lsu_acc.be[i]}};
                D[i]    = lsu_acc.wdata[i*BANK_DW +: BANK_DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else if (if_gnt) begin
            owner <= OWN_IF;
        end else if (lsu_gnt && !lsu_acc.we) begin
            owner <= OWN_LSU;
        end else begin
            owner <= OWN_NONE;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_win <= OWN_LSU;
        end else if (if_gnt) begin
            last_win <= OWN_IF;
        end else if (lsu_gnt) begin
            last_win <= OWN_LSU;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst || !if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_LIM) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // Response valids follow the registered owner; reset masks them in the
    // same cycle so a grant just before reset is dropped.
    assign if_rvalid  = !rst && (owner == OWN_IF);
    assign lsu_rvalid = !rst && (owner == OWN_LSU);
    assign if_rdata   = {Q[3], Q[2], Q[1], Q[0]};
    assign lsu_rdata  = {Q[3], Q[2], Q[1], Q[0]};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter with a behavioural
// 4-bank SRAM model (read returns old contents the cycle after access).
module tb_sram_port_arbiter;

    localparam int BANK_AW = 9;

    logic               clk;
    logic               rst;
    logic               if_req;
    logic [31:0]        if_addr;
    logic               if_gnt;
    logic               if_rvalid;
    logic [31:0]        if_rdata;
    logic               lsu_req;
    logic               lsu_we;
    logic [3:0]         lsu_be;
    logic [31:0]        lsu_addr;
    logic [31:0]        lsu_wdata;
    logic               lsu_gnt;
    logic               lsu_rvalid;
    logic [31:0]        lsu_rdata;
    logic               CEN  [0:3];
    logic               GWEN [0:3];
    logic [7:0]         WEN  [0:3];
    logic [BANK_AW-1:0] A    [0:3];
    logic [7:0]         D    [0:3];
    logic [7:0]         Q    [0:3];

    logic [7:0]         mem [0:3][0:(1<<BANK_AW)-1];

    int n_checks;
    int n_fail;

    sram_port_arbiter #(.BANK_AW(BANK_AW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .CEN(CEN), .GWEN(GWEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!CEN[b]) begin
                if (!GWEN[b])
                    mem[b][A[b]] <= (mem[b][A[b]] & WEN[b]) | (D[b] & ~WEN[b]);
                Q[b] <= mem[b][A[b]];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        if_req   = 1'b0;
        if_addr  = '0;
        lsu_req  = 1'b0;
        lsu_we   = 1'b0;
        lsu_be   = '0;
        lsu_addr = '0;
        lsu_wdata = '0;
    endtask

    task automatic check_sram_idle(input string tag);
        check({tag, "_cen"},  {31'd0, &{CEN[0], CEN[1], CEN[2], CEN[3]}}, 32'd1);
        check({tag, "_gwen"}, {28'd0, GWEN[3], GWEN[2], GWEN[1], GWEN[0]}, 32'hF);
        check({tag, "_wen"},  {WEN[3], WEN[2], WEN[1], WEN[0]}, 32'hFFFF_FFFF);
        check({tag, "_a"},    {23'd0, A[0] | A[1] | A[2] | A[3]}, 32'd0);
        check({tag, "_d"},    {D[3], D[2], D[1], D[0]}, 32'd0);
    endtask

    logic exp_if;
    logic prev_if;
    logic prev_lsu;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < (1<<BANK_AW); w++)
                mem[b][w] = 8'h00;
        {mem[3][4], mem[2][4], mem[1][4], mem[0][4]} = 32'hDEAD_BEEF;
        for (int b = 0; b < 4; b++) Q[b] = 8'h00;
        rst = 1'b1;
        idle();

        // Reset with a pending fetch: nothing granted, SRAM idle.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        check("rst_lsu_gnt", {31'd0, lsu_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, if_rvalid, lsu_rvalid}, 32'd0);
        check_sram_idle("rst");
        @(negedge clk);
        idle();

        // Fetch only from word 4.
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        check("fetch_gnt", {30'd0, if_gnt, lsu_gnt}, 32'd2);
        check("fetch_cen", {28'd0, CEN[3], CEN[2], CEN[1], CEN[0]}, 32'd0);
        check("fetch_a", {A[3][7:0], A[2][7:0], A[1][7:0], A[0][7:0]}, 32'h0404_0404);
        check("fetch_gwen", {28'd0, GWEN[3], GWEN[2], GWEN[1], GWEN[0]}, 32'hF);
        @(negedge clk);
        idle();
        #1;
        check("fetch_rvalid", {30'd0, if_rvalid, lsu_rvalid}, 32'd2);
        check("fetch_rdata", if_rdata, 32'hDEAD_BEEF);
        check_sram_idle("after_fetch");

        // Partial store to 0x20 then load it back.
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0101;
        lsu_addr = 32'h20; lsu_wdata = 32'h1122_3344;
        #1;
        check("store_gnt", {30'd0, if_gnt, lsu_gnt}, 32'd1);
        check("store_gwen", {28'd0, GWEN[3], GWEN[2], GWEN[1], GWEN[0]}, 32'hA);
        check("store_wen", {WEN[3], WEN[2], WEN[1], WEN[0]}, 32'hFF00_FF00);
        check("store_d", {D[3], D[2], D[1], D[0]}, 32'h1122_3344);
        check("store_a", {23'd0, A[2]}, 32'd8);
        @(negedge clk);
        lsu_we = 1'b0; lsu_be = 4'b0000; lsu_wdata = '0;
        #1;
        check("store_no_rvalid", {30'd0, if_rvalid, lsu_rvalid}, 32'd0);
        check("load_gnt", {30'd0, if_gnt, lsu_gnt}, 32'd1);
        check("load_gwen", {28'd0, GWEN[3], GWEN[2], GWEN[1], GWEN[0]}, 32'hF);
        @(negedge clk);
        idle();
        #1;
        check("load_rvalid", {30'd0, if_rvalid, lsu_rvalid}, 32'd1);
        check("load_rdata", lsu_rdata, 32'h0022_0044);

        // Store with no byte enables: granted, writes nothing.
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0000;
        lsu_addr = 32'h24; lsu_wdata = 32'hFFFF_FFFF;
        #1;
        check("be0_gnt", {30'd0, if_gnt, lsu_gnt}, 32'd1);
        check("be0_gwen", {28'd0, GWEN[3], GWEN[2], GWEN[1], GWEN[0]}, 32'hF);
        check("be0_wen", {WEN[3], WEN[2], WEN[1], WEN[0]}, 32'hFFFF_FFFF);
        @(negedge clk);
        lsu_we = 1'b0; lsu_wdata = '0;
        #1;
        check("be0_no_rvalid", {31'd0, lsu_rvalid}, 32'd0);
        @(negedge clk);
        idle();
        #1;
        check("be0_load_rvalid", {31'd0, lsu_rvalid}, 32'd1);
        check("be0_load_rdata", lsu_rdata, 32'h0000_0000);

        // Continuous contention: fetch of word 4 against load of word 8.
        prev_if = 1'b0;
        prev_lsu = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if_req = 1'b1; if_addr = 32'h10;
            lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h20;
            #1;
`ifdef ARB_ROUND_ROBIN_EN
            exp_if = (k % 2 == 0);
`else
            exp_if = (k % 5 == 4);
`endif
            check($sformatf("cont_gnt_%0d", k), {30'd0, if_gnt, lsu_gnt}, {30'd0, exp_if, !exp_if});
            check($sformatf("cont_rvalid_%0d", k), {30'd0, if_rvalid, lsu_rvalid}, {30'd0, prev_if, prev_lsu});
            if (prev_if)
                check($sformatf("cont_if_rdata_%0d", k), if_rdata, 32'hDEAD_BEEF);
            if (prev_lsu)
                check($sformatf("cont_lsu_rdata_%0d", k), lsu_rdata, 32'h0022_0044);
            prev_if = exp_if;
            prev_lsu = !exp_if;
        end
        @(negedge clk);
        idle();
        #1;
        check("cont_last_rvalid", {30'd0, if_rvalid, lsu_rvalid}, {30'd0, prev_if, prev_lsu});

        // Address bits above the bank index wrap.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0804;
        #1;
        check("wrap_a0", {23'd0, A[0]}, 32'd1);
        check("wrap_a3", {23'd0, A[3]}, 32'd1);

        // Reset the cycle after a fetch grant: response is dropped.
        @(negedge clk);
        if_addr = 32'h10;
        #1;
        check("pre_rst_gnt", {31'd0, if_gnt}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_rvalid", {30'd0, if_rvalid, lsu_rvalid}, 32'd0);
        check("midrst_gnt", {30'd0, if_gnt, lsu_gnt}, 32'd0);
        check_sram_idle("midrst");
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        check("post_rst_rvalid", {30'd0, if_rvalid, lsu_rvalid}, 32'd0);
        check("post_rst_cen", {28'd0, CEN[3], CEN[2], CEN[1], CEN[0]}, 32'hF);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
